// File: rtl/uart_tx_unit_if.sv
// Host-side bundle for the UART transmitter: request, byte, frame format and line status.
//
// Handshake: the host raises `send` with `data_in`, `parity_type` and `baud_rate`
// valid in the same cycle. The transmitter is ready only while its FSM is idle,
// and that includes the single `done_flag` cycle. When send and ready are both
// high at a rising clock edge, the request is taken. A request made while the
// transmitter is busy is dropped, not held. The host learns that the frame has
// finished from the one-cycle `done_flag` pulse.
interface uart_tx_unit_if;
    logic       send;
    logic [7:0] data_in;
    logic [1:0] parity_type;
    logic [1:0] baud_rate;
    logic       data_tx;
    logic       active_flag;
    logic       done_flag;
    logic [2:0] dbg_state;

    modport master (
        output send, data_in, parity_type, baud_rate,
        input  data_tx, active_flag, done_flag, dbg_state
    );

    modport slave (
        input  send, data_in, parity_type, baud_rate,
        output data_tx, active_flag, done_flag, dbg_state
    );
endinterface

// File: rtl/uart_tx_unit.sv
// UART transmitter: sends one 11-bit frame (start, d0..d7, parity, stop), LSB first.
// The baud tick comes from an internal divider. Every bit lasts DIV clocks, where
// DIV = CLK_FREQ / baud. The line output and the status flags are registered.
// Each of them follows the FSM state one clock later, so a request taken at edge N
// shows its start bit from edge N+1.
module uart_tx_unit #(
    parameter int CLK_FREQ = 50000000
) (
    input  logic           clock,
    input  logic           rst,
    uart_tx_unit_if.slave  bus
);
    localparam logic [15:0] DIV_2400  = 16'(CLK_FREQ / 2400);
    localparam logic [15:0] DIV_4800  = 16'(CLK_FREQ / 4800);
    localparam logic [15:0] DIV_9600  = 16'(CLK_FREQ / 9600);
    localparam logic [15:0] DIV_19200 = 16'(CLK_FREQ / 19200);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_div;
    logic [15:0] r_baud_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_parity;
    logic        r_data_tx;
    logic        r_active;
    logic        r_done;

    logic [15:0] w_div_sel;
    logic        w_parity_sel;
    logic        w_accept;
    logic        w_bit_end;
    logic        w_tx_next;
    logic        w_active_next;
    logic        w_done_next;

    assign w_accept  = (r_state == S_IDLE) && bus.send;
    assign w_bit_end = (r_state != S_IDLE) && (r_baud_cnt == (r_div - 16'd1));

    // Select the divisor and the parity bit for the request now on the inputs.
    always_comb begin
        w_div_sel = DIV_2400;
        case (bus.baud_rate)
            2'b00:   w_div_sel = DIV_2400;
            2'b01:   w_div_sel = DIV_4800;
            2'b10:   w_div_sel = DIV_9600;
            default: w_div_sel = DIV_19200;
        endcase
        w_parity_sel = 1'b1;
        case (bus.parity_type)
            2'b01:   w_parity_sel = ~^bus.data_in;
            2'b10:   w_parity_sel = ^bus.data_in;
            default: w_parity_sel = 1'b1;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: a frame step happens only at the end of a bit period.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next_state = S_START;
            S_START:  if (w_bit_end) w_next_state = S_DATA;
            S_DATA:   if (w_bit_end && (r_bit_cnt == 3'd7)) w_next_state = S_PARITY;
            S_PARITY: if (w_bit_end) w_next_state = S_STOP;
            S_STOP:   if (w_bit_end) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Output decode: the line level and the flags that the current state calls for.
    always_comb begin
        w_tx_next     = 1'b1;
        w_active_next = (r_state != S_IDLE);
        // Idle while the active flag is still set means STOP has just ended.
        w_done_next   = (r_state == S_IDLE) && r_active;
        case (r_state)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = r_shift[0];
            S_PARITY: w_tx_next = r_parity;
            default:  w_tx_next = 1'b1;
        endcase
    end

    // Registered outputs, so the serial line has no path from any input.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_data_tx <= 1'b1;
            r_active  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_data_tx <= w_tx_next;
            r_active  <= w_active_next;
            r_done    <= w_done_next;
        end
    end

    // Datapath: capture the request, run the baud counter, shift out data bits.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_div      <= 16'd0;
            r_baud_cnt <= 16'd0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'd0;
            r_parity   <= 1'b1;
        end else begin
            if (w_accept) begin
                r_div     <= w_div_sel;
                r_shift   <= bus.data_in;
                r_parity  <= w_parity_sel;
                r_bit_cnt <= 3'd0;
            end else if ((r_state == S_DATA) && w_bit_end) begin
                r_shift   <= r_shift >> 1;
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if ((r_state == S_IDLE) || w_bit_end) begin
                r_baud_cnt <= 16'd0;
            end else begin
                r_baud_cnt <= r_baud_cnt + 16'd1;
            end
        end
    end

    assign bus.data_tx     = r_data_tx;
    assign bus.active_flag = r_active;
    assign bus.done_flag   = r_done;
    assign bus.dbg_state   = r_state;
endmodule

// File: tb/tb_uart_tx_unit.sv
// Testbench for uart_tx_unit. A frame model works out the expected 11-bit frame and
// its timing, and the bench compares the line and the flags with it on every clock.
module tb_uart_tx_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [10:0] exp_q[$];

  uart_tx_unit_if bus();

  uart_tx_unit #(.CLK_FREQ(192000)) dut (
    .clock(clk),
    .rst(rst_n),
    .bus(bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int div_of(input logic [1:0] br);
    int rate;
    rate = 2400 << br;
    return 192000 / rate;
  endfunction

  function automatic logic [10:0] frame_of(input logic [7:0] d, input logic [1:0] pt);
    logic par;
    if (pt == 2'b01) par = ~^d;
    else if (pt == 2'b10) par = ^d;
    else par = 1'b1;
    return {1'b1, par, d, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: present a request; the edge after this call is edge N
  task automatic start_frame(input logic [7:0] d, input logic [1:0] pt, input logic [1:0] br,
                             input bit keep);
    bus.send = 1'b1;
    bus.data_in = d;
    bus.parity_type = pt;
    bus.baud_rate = br;
    exp_q.push_back(frame_of(d, pt));
    tick();
    if (!keep) bus.send = 1'b0;
  endtask

  // Check one frame, cycle by cycle, starting just after edge N. The optional
  // injection at cycle inj_cyc raises send and changes the data and the parity setting.
  task automatic frame_check(input logic [1:0] br, input int inj_cyc, input logic [7:0] inj_d,
                             input logic [1:0] inj_pt, input bit keep);
    int div;
    logic [10:0] f;
    div = div_of(br);
    if (exp_q.size() == 0) begin
      check("sb_empty", 16'd0, 16'd1);
      return;
    end
    f = exp_q.pop_front();
    for (int c = 1; c <= 11 * div + 1; c++) begin
      tick();
      if (c <= 11 * div) begin
        check("tx", {15'd0, bus.data_tx}, {15'd0, f[(c - 1) / div]});
        check("active", {15'd0, bus.active_flag}, 16'd1);
        check("done_low", {15'd0, bus.done_flag}, 16'd0);
      end else begin
        check("tx_end", {15'd0, bus.data_tx}, 16'd1);
        check("done_pulse", {15'd0, bus.done_flag}, 16'd1);
        check("active_end", {15'd0, bus.active_flag}, 16'd0);
      end
      if (inj_cyc != 0 && c == inj_cyc) begin
        bus.send = 1'b1;
        bus.data_in = inj_d;
        bus.parity_type = inj_pt;
      end
      if (inj_cyc != 0 && c == inj_cyc + 1 && !keep) bus.send = 1'b0;
    end
  endtask

  task automatic check_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check({tag, "_tx"}, {15'd0, bus.data_tx}, 16'd1);
      check({tag, "_active"}, {15'd0, bus.active_flag}, 16'd0);
      check({tag, "_done"}, {15'd0, bus.done_flag}, 16'd0);
    end
  endtask

  initial begin
    logic [10:0] f;
    logic [7:0] rd;
    logic [1:0] rp;
    logic [1:0] rb;
    bus.send = 1'b0;
    bus.data_in = 8'h00;
    bus.parity_type = 2'b00;
    bus.baud_rate = 2'b11;

    // power-on reset
    check_idle("por", 3);
    rst_n = 1'b1;
    check_idle("por_rel", 3);

    // basic frame, even parity
    start_frame(8'hA5, 2'b10, 2'b11, 1'b0);
    frame_check(2'b11, 0, 8'h00, 2'b00, 1'b0);
    check_idle("after_a5", 2);

    // odd parity, then no parity requested during the done cycle
    start_frame(8'h01, 2'b01, 2'b11, 1'b0);
    frame_check(2'b11, 0, 8'h00, 2'b00, 1'b0);
    start_frame(8'h01, 2'b00, 2'b11, 1'b0);
    frame_check(2'b11, 0, 8'h00, 2'b00, 1'b0);
    check_idle("after_01", 2);

    // slowest baud rate
    start_frame(8'hFF, 2'b10, 2'b00, 1'b0);
    frame_check(2'b00, 0, 8'h00, 2'b00, 1'b0);
    check_idle("after_ff", 2);

    // send pulse and parity change during a frame are ignored
    start_frame(8'h96, 2'b01, 2'b11, 1'b0);
    frame_check(2'b11, 30, 8'h3C, 2'b10, 1'b0);
    check_idle("busy_drop", 4);

    // send held high: back-to-back frames; data changes mid-frame feed the next one
    start_frame(8'h9A, 2'b10, 2'b10, 1'b1);
    frame_check(2'b10, 50, 8'h55, 2'b01, 1'b1);
    exp_q.push_back(frame_of(8'h55, 2'b01));
    bus.send = 1'b0;
    frame_check(2'b10, 0, 8'h00, 2'b00, 1'b0);
    check_idle("after_hold", 3);

    // randomized frames at the two fastest rates
    for (int k = 0; k < 6; k++) begin
      rd = 8'($urandom);
      rp = 2'($urandom_range(0, 3));
      rb = 2'($urandom_range(2, 3));
      start_frame(rd, rp, rb, 1'b0);
      frame_check(rb, 0, 8'h00, 2'b00, 1'b0);
      check_idle("rnd_gap", 1);
    end

    // mid-frame reset during data bit 4
    f = frame_of(8'hE7, 2'b10);
    bus.send = 1'b1;
    bus.data_in = 8'hE7;
    bus.parity_type = 2'b10;
    bus.baud_rate = 2'b11;
    tick();
    bus.send = 1'b0;
    for (int c = 1; c <= 54; c++) tick();
    check("pre_rst_tx", {15'd0, bus.data_tx}, {15'd0, f[5]});
    check("pre_rst_active", {15'd0, bus.active_flag}, 16'd1);
    rst_n = 1'b0;
    #1;
    check("rst_tx_async", {15'd0, bus.data_tx}, 16'd1);
    check("rst_active_async", {15'd0, bus.active_flag}, 16'd0);
    check_idle("in_rst", 3);
    rst_n = 1'b1;
    check_idle("post_rst", 20);
    start_frame(8'hC3, 2'b01, 2'b11, 1'b0);
    frame_check(2'b11, 0, 8'h00, 2'b00, 1'b0);

    // reset with no traffic
    check_idle("pre_idle_rst", 2);
    rst_n = 1'b0;
    check_idle("idle_rst", 3);
    rst_n = 1'b1;
    check_idle("idle_rst_rel", 3);

    check("sb_drained", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
